// File: rtl/ads_spi_axil_regs.sv
// AXI4-Lite register file between the interconnect master and the ADS SPI core.
// Ports: s00_axi_* AXI4-Lite responder; ctrl_out/cmd_out/cmd_start drive the core;
//        core_done/core_busy/sample_valid/sample_data report core status and samples.
// Registers: 0x0 CTRL rw, 0x4 CMD rw (write pulses cmd_start), 0x8 STATUS w1c/ro, 0xC DATA ro.
module ads_spi_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_out,
  output logic                            cmd_start,
  input  logic                            core_done,
  input  logic                            core_busy,
  input  logic                            sample_valid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   sample_data
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Short aliases
  logic clk, rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  // ---------------- write channel state ----------------
  logic          aw_held, w_held;
  logic [AW-1:2] aw_addr;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          bvalid_q;
  logic [1:0]    bresp_q;

  logic [31:0] ctrl_q, cmd_q, data_q;
  logic        done_q, overrun_q, unread_q;
  logic        cmd_start_q;

  // ---------------- read channel state ----------------
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  // Readies are gated by reset so handshakes drop the moment reset asserts,
  // not just at the next edge.
  logic awready_int, wready_int, arready_int;
  assign awready_int = !rst && !aw_held && !bvalid_q;
  assign wready_int  = !rst && !w_held  && !bvalid_q;
  assign arready_int = !rst && !rvalid_q;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s00_axi_awvalid && awready_int;
  assign w_hs  = s00_axi_wvalid  && wready_int;
  assign ar_hs = s00_axi_arvalid && arready_int;

  // Commit fires once, in the cycle after both halves are held; bvalid then
  // blocks any further commit until the response is accepted.
  logic       commit, wr_oor;
  logic [1:0] wr_sel;
  assign wr_oor = (AW > 4) ? |aw_addr[AW-1:4] : 1'b0;
  assign wr_sel = aw_addr[3:2];
  assign commit = aw_held && w_held && !bvalid_q;

  logic wr_ctrl, wr_cmd, wr_status;
  assign wr_ctrl   = commit && !wr_oor && (wr_sel == 2'd0);
  assign wr_cmd    = commit && !wr_oor && (wr_sel == 2'd1);
  assign wr_status = commit && !wr_oor && (wr_sel == 2'd2);

  // Flags live in byte 0, so only wstrb[0] can clear them.
  logic clr_done, clr_overrun;
  assign clr_done    = wr_status && w_strb[0] && w_data[0];
  assign clr_overrun = wr_status && w_strb[0] && w_data[1];

  logic       rd_oor;
  logic [1:0] rd_sel;
  logic       rd_data_hs;
  assign rd_oor     = (AW > 4) ? |s00_axi_araddr[AW-1:4] : 1'b0;
  assign rd_sel     = s00_axi_araddr[3:2];
  assign rd_data_hs = ar_hs && !rd_oor && (rd_sel == 2'd3);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Write address/data latches and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s00_axi_awaddr[AW-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata[31:0];
        w_strb <= s00_axi_wstrb[3:0];
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  // CTRL / CMD registers and the launch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      cmd_q       <= '0;
      cmd_start_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= merge_bytes(ctrl_q, w_data, w_strb);
      if (wr_cmd)  cmd_q  <= merge_bytes(cmd_q, w_data, w_strb);
      // Any CMD commit launches, even with no byte enabled.
      cmd_start_q <= wr_cmd;
    end
  end

  // Sample capture and sticky flags; a set always beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      unread_q  <= 1'b0;
    end else begin
      if (sample_valid) data_q <= sample_data[31:0];
      done_q <= core_done || (done_q && !clr_done);
      // A sample arriving as DATA is being read replaces a value that is
      // being consumed, so it is not an overrun.
      overrun_q <= (sample_valid && unread_q && !rd_data_hs) ||
                   (overrun_q && !clr_overrun);
      if (sample_valid)    unread_q <= 1'b1;
      else if (rd_data_hs) unread_q <= 1'b0;
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0:    rd_mux = ctrl_q;
      2'd1:    rd_mux = cmd_q;
      2'd2:    rd_mux = {28'd0, unread_q, core_busy, overrun_q, done_q};
      default: rd_mux = data_q;
    endcase
  end

  // Read channel: data registered on the AR handshake, one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= rd_oor ? 32'd0 : rd_mux;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s00_axi_awready = awready_int;
  assign s00_axi_wready  = wready_int;
  assign s00_axi_arready = arready_int;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign ctrl_out        = ctrl_q;
  assign cmd_out         = cmd_q;
  assign cmd_start       = cmd_start_q;

  // Byte-lane address bits carry no register selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_ads_spi_axil_regs.sv
module tb_ads_spi_axil_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] ctrl_out, cmd_out;
  logic        cmd_start;
  logic        core_done = 1'b0;
  logic        core_busy = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;
  int cmd_misalign = 0;

  always #5 clk = ~clk;

  ads_spi_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ctrl_out(ctrl_out), .cmd_out(cmd_out), .cmd_start(cmd_start),
    .core_done(core_done), .core_busy(core_busy),
    .sample_valid(sample_valid), .sample_data(sample_data)
  );

  // cmd_start must appear together with the first bvalid cycle of its commit
  always @(negedge clk) begin
    if (cmd_start) begin
      cmd_cnt++;
      if (!bvalid) cmd_misalign++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    bit a_hs, w_hs, ad, wd;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    ad = 0; wd = 0; n = 0;
    while (!(ad && wd) && n < 50) begin
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(negedge clk);
      if (a_hs) begin awvalid = 1'b0; ad = 1; end
      if (w_hs) begin wvalid = 1'b0; wd = 1; end
      n++;
    end
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h", a);
      awvalid = 1'b0; wvalid = 1'b0;
      resp = 2'b11;
    end else begin
      resp = bresp;
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_latency_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
    resp = rresp;
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [5:0] addr, logic [31:0] data,
                              logic [3:0] strb, logic [1:0] resp, logic [31:0] rdat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.resp = resp; v.rdat = rdat;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int n;

    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int n;

    vecs[0]  = mk(1, 6'h00, 32'd1,        4'hF, 2'b00, 32'd0);
    vecs[1]  = mk(1, 6'h04, 32'd2,        4'hF, 2'b00, 32'd0);
    vecs[2]  = mk(1, 6'h08, 32'd3,        4'hF, 2'b00, 32'd0);
    vecs[3]  = mk(1, 6'h0C, 32'd4,        4'hF, 2'b00, 32'd0);
    vecs[4]  = mk(0, 6'h00, 32'd0,        4'h0, 2'b00, 32'd1);
    vecs[5]  = mk(0, 6'h04, 32'd0,        4'h0, 2'b00, 32'd2);
    vecs[6]  = mk(0, 6'h08, 32'd0,        4'h0, 2'b00, 32'd0);
    vecs[7]  = mk(0, 6'h0C, 32'd0,        4'h0, 2'b00, 32'd0);
    vecs[8]  = mk(1, 6'h04, 32'hFFFFFFFF, 4'h0, 2'b00, 32'd0);
    vecs[9]  = mk(0, 6'h04, 32'd0,        4'h0, 2'b00, 32'd2);
    vecs[10] = mk(1, 6'h10, 32'hDEAD,     4'hF, 2'b10, 32'd0);
    vecs[11] = mk(0, 6'h10, 32'd0,        4'h0, 2'b10, 32'd0);
    vecs[12] = mk(0, 6'h00, 32'd0,        4'h0, 2'b00, 32'd1);
    vecs[13] = mk(0, 6'h3C, 32'd0,        4'h0, 2'b10, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata,    32'd0);
    chk("rst_ctrl",    ctrl_out, 32'd0);
    chk("rst_cmd",     cmd_out,  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);

    // Register map, strobes, out-of-range
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].resp});
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdat);
      end
    end
    chk("cmd_start_count", cmd_cnt, 32'd2);
    chk("cmd_start_align", cmd_misalign, 32'd0);

    // W three cycles ahead of AW, partial strobes, stalled response
    bready = 1'b0;
    @(negedge clk);
    wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1'b1;
    chk("early_w_wready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("early_w_no_bvalid", {31'd0, bvalid}, 32'd0);
    chk("early_w_wready_low", {31'd0, wready}, 32'd0);
    awaddr = 6'h00; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 5) begin @(negedge clk); n++; end
    chk("late_aw_bvalid", {31'd0, bvalid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {29'd0, bvalid, awready, wready}, 32'b100);
    end
    chk("stall_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    chk("stall_release", {29'd0, bvalid, awready, wready}, 32'b011);
    chk("strobe_ctrl", ctrl_out, 32'h00A500A5);

    // DONE sticky, set beats W1C
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    axi_read(6'h08, d, r);
    chk("done_set", d, 32'h1);
    @(negedge clk);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("done_race_bvalid", {31'd0, bvalid}, 32'd1);
    @(negedge clk);
    axi_read(6'h08, d, r);
    chk("done_set_wins", d, 32'h1);
    axi_write(6'h08, 32'h1, 4'hF, r);
    axi_read(6'h08, d, r);
    chk("done_cleared", d, 32'h0);

    // Samples, overrun, unread
    @(negedge clk); sample_valid = 1'b1; sample_data = 32'h11;
    @(negedge clk); sample_data = 32'h22;
    @(negedge clk); sample_valid = 1'b0;
    axi_read(6'h08, d, r);
    chk("status_overrun", d, 32'hA);
    axi_read(6'h0C, d, r);
    chk("data_latest", d, 32'h22);
    axi_read(6'h08, d, r);
    chk("status_after_read", d, 32'h2);
    axi_write(6'h08, 32'h2, 4'hF, r);
    @(negedge clk); sample_valid = 1'b1; sample_data = 32'h33;
    @(negedge clk); sample_valid = 1'b0;
    // DATA read handshake coincides with a new sample
    @(negedge clk);
    chk("race_arready", {31'd0, arready}, 32'd1);
    araddr = 6'h0C; arvalid = 1'b1; sample_valid = 1'b1; sample_data = 32'h44;
    @(negedge clk);
    arvalid = 1'b0; sample_valid = 1'b0;
    chk("race_old_data", rdata, 32'h33);
    core_busy = 1'b1;
    axi_read(6'h08, d, r);
    chk("race_status", d, 32'hC);
    core_busy = 1'b0;
    axi_read(6'h0C, d, r);
    chk("race_new_data", d, 32'h44);

    // Reset with AW latched and W pending
    @(negedge clk);
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h5555; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; rst = 1'b1;
    #1;
    chk("mid_rst_readies", {30'd0, awready, wready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_ctrl", ctrl_out, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd1);
    axi_write(6'h00, 32'h12345678, 4'hF, r);
    chk("post_rst_bresp", {30'd0, r}, 32'd0);
    axi_read(6'h00, d, r);
    chk("post_rst_ctrl", d, 32'h12345678);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
